// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: instruction field
// positions, the NOP word and the fetch-stage FSM encoding.
package mips_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DRAIN = 2'd2
  } if_state_e;

  function automatic logic [5:0] op_of(input logic [INSTR_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] funct_of(input logic [INSTR_W-1:0] w);
    return w[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding {instr, pc4} for a fetched word that
// arrived while IF/ID was stalled.
module if_skid_buf
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] din_instr,
  input  logic [31:0]        din_pc4,
  output logic               full,
  output logic [INSTR_W-1:0] dout_instr,
  output logic [31:0]        dout_pc4
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      instr_d = din_instr;
      pc4_d   = din_pc4;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign full       = full_q;
  assign dout_instr = instr_q;
  assign dout_pc4   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// feeds the IF/ID register, with stall skid buffering and branch redirect.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [5:0]         ifid_op,
  output logic [5:0]         ifid_funct,
  output logic [31:0]        ifid_pc4
);

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic               req_q, req_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [31:0]        ifid_pc4_q, ifid_pc4_d;

  logic               ack_v, ifid_free;
  logic               skid_load, skid_unload, skid_clear, skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc4;

  if_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .din_instr  (imem_rdata),
    .din_pc4    (pc_q + PC_STEP),
    .full       (skid_full),
    .dout_instr (skid_instr),
    .dout_pc4   (skid_pc4)
  );

  always_comb begin
    ack_v        = imem_ack && req_q;
    ifid_free    = !ifid_valid_q || !stall;
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q && stall;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    if (redirect) begin
      pc_d         = redirect_pc & ~32'h3;
      ifid_valid_d = 1'b0;
      skid_clear   = 1'b1;
      unique case (state_q)
        FETCH:   state_d = (req_q && !ack_v) ? DRAIN : FETCH;
        // An ack landing with a repeat redirect retires the stale request.
        DRAIN:   state_d = ack_v ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack_v) begin
            pc_d = pc_q + PC_STEP;
            if (ifid_free) begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc4_d   = pc_q + PC_STEP;
            end else begin
              skid_load = 1'b1;
              state_d   = SKID;
            end
          end
        end
        SKID: begin
          if (ifid_free && skid_full) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = skid_instr;
            ifid_pc4_d   = skid_pc4;
            skid_unload  = 1'b1;
            state_d      = FETCH;
          end
        end
        DRAIN: begin
          if (ack_v) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end

    // DRAIN keeps the in-flight address stable while pc already holds the target.
    req_d  = (state_d != SKID);
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      addr_q       <= PC_INIT;
      req_q        <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_op    = op_of(ifid_instr_q);
  assign ifid_funct = funct_of(ifid_instr_q);
  assign ifid_pc4   = ifid_pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall/skid, redirect with
// delayed ack, same-cycle redirect/stall/ack, PC wrap and mid-wait reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_op;
  logic [5:0]  ifid_funct;
  logic [31:0] ifid_pc4;

  int n_cmp = 0;
  int n_err = 0;

  if_stage #(
    .RESET_PC (32'h0040_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_op     (ifid_op),
    .ifid_funct  (ifid_funct),
    .ifid_pc4    (ifid_pc4)
  );

  always #5 clk = ~clk;

  // Memory model: the reset vector holds add $2,$4,$5; other words tag their address.
  always_comb begin
    if (imem_addr == 32'h0040_0000) imem_rdata = 32'h0085_1020;
    else                            imem_rdata = {8'hC0, imem_addr[23:0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #2;
    check("rst_req",   {31'd0, imem_req},   32'd0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_addr",  imem_addr,           32'h0040_0000);
    check("rst_instr", ifid_instr,          32'd0);
    check("rst_pc4",   ifid_pc4,            32'd0);

    tick(); tick();
    rst      = 1'b0;
    imem_ack = 1'b1;
    tick();                                           // E1: request raised
    check("e1_req",   {31'd0, imem_req},   32'd1);
    check("e1_addr",  imem_addr,           32'h0040_0000);
    check("e1_valid", {31'd0, ifid_valid}, 32'd0);

    tick();                                           // E2: first word
    check("e2_valid", {31'd0, ifid_valid}, 32'd1);
    check("e2_instr", ifid_instr,          32'h0085_1020);
    check("e2_op",    {26'd0, ifid_op},    32'h00);
    check("e2_funct", {26'd0, ifid_funct}, 32'h20);
    check("e2_pc4",   ifid_pc4,            32'h0040_0004);
    check("e2_addr",  imem_addr,           32'h0040_0004);

    tick();                                           // E3
    check("e3_instr", ifid_instr, 32'hC040_0004);
    check("e3_pc4",   ifid_pc4,   32'h0040_0008);
    check("e3_addr",  imem_addr,  32'h0040_0008);

    stall = 1'b1;
    tick();                                           // E4: word to skid
    check("e4_req",   {31'd0, imem_req},   32'd0);
    check("e4_valid", {31'd0, ifid_valid}, 32'd1);
    check("e4_instr", ifid_instr,          32'hC040_0004);
    check("e4_pc4",   ifid_pc4,            32'h0040_0008);
    tick();                                           // E5
    check("e5_req",   {31'd0, imem_req}, 32'd0);
    check("e5_instr", ifid_instr,        32'hC040_0004);
    tick();                                           // E6
    check("e6_instr", ifid_instr,        32'hC040_0004);
    check("e6_pc4",   ifid_pc4,          32'h0040_0008);

    stall = 1'b0;
    tick();                                           // E7: skid drains
    check("e7_valid", {31'd0, ifid_valid}, 32'd1);
    check("e7_instr", ifid_instr,          32'hC040_0008);
    check("e7_pc4",   ifid_pc4,            32'h0040_000C);
    check("e7_req",   {31'd0, imem_req},   32'd1);
    check("e7_addr",  imem_addr,           32'h0040_000C);
    tick();                                           // E8
    check("e8_instr", ifid_instr, 32'hC040_000C);
    check("e8_pc4",   ifid_pc4,   32'h0040_0010);

    imem_ack = 1'b0;
    tick();                                           // E9: consumed, waiting
    check("e9_valid", {31'd0, ifid_valid}, 32'd0);
    check("e9_addr",  imem_addr,           32'h0040_0010);

    redirect    = 1'b1;
    redirect_pc = 32'h0040_0101;
    tick();                                           // E10: enter DRAIN
    redirect = 1'b0;
    check("e10_valid", {31'd0, ifid_valid}, 32'd0);
    check("e10_req",   {31'd0, imem_req},   32'd1);
    check("e10_addr",  imem_addr,           32'h0040_0010);
    tick();                                           // E11
    check("e11_addr",  imem_addr,           32'h0040_0010);
    imem_ack = 1'b1;
    tick();                                           // E12: stale data dropped
    check("e12_valid", {31'd0, ifid_valid}, 32'd0);
    check("e12_addr",  imem_addr,           32'h0040_0100);
    tick();                                           // E13: target word
    check("e13_valid", {31'd0, ifid_valid}, 32'd1);
    check("e13_instr", ifid_instr,          32'hC040_0100);
    check("e13_pc4",   ifid_pc4,            32'h0040_0104);

    redirect    = 1'b1;
    redirect_pc = 32'h0040_0200;
    stall       = 1'b1;
    tick();                                           // E14: all three at once
    check("e14_valid", {31'd0, ifid_valid}, 32'd0);
    check("e14_addr",  imem_addr,           32'h0040_0200);
    check("e14_req",   {31'd0, imem_req},   32'd1);
    check("e14_stale", ifid_instr,          32'hC040_0100);

    stall       = 1'b0;
    imem_ack    = 1'b0;
    redirect_pc = 32'hFFFF_FFFC;
    tick();                                           // E15: DRAIN toward top
    redirect = 1'b0;
    check("e15_addr", imem_addr, 32'h0040_0200);
    imem_ack = 1'b1;
    tick();                                           // E16
    check("e16_addr", imem_addr, 32'hFFFF_FFFC);
    stall = 1'b1;
    tick();                                           // E17: wrap
    check("e17_instr", ifid_instr, 32'hC0FF_FFFC);
    check("e17_pc4",   ifid_pc4,   32'h0000_0000);
    check("e17_addr",  imem_addr,  32'h0000_0000);

    imem_ack = 1'b0;
    tick();                                           // E18: waiting, IF/ID held
    check("e18_valid", {31'd0, ifid_valid}, 32'd1);
    check("e18_req",   {31'd0, imem_req},   32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",   {31'd0, imem_req},   32'd0);
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_addr",  imem_addr,           32'h0040_0000);

    tick();
    rst      = 1'b0;
    stall    = 1'b0;
    imem_ack = 1'b1;
    tick();                                           // ack while req was low ignored
    check("post_valid", {31'd0, ifid_valid}, 32'd0);
    check("post_addr",  imem_addr,           32'h0040_0000);
    tick();
    check("post_instr", ifid_instr, 32'h0085_1020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
